// File: rtl/qpsk_demod.sv
// qpsk_demod: recovers the serial bit stream from a 1-bit QPSK square-wave carrier by majority vote on rising-edge phase
module qpsk_demod #(
  parameter int CAR_LEN = 4,
  parameter int SYM_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       y,
  output logic       x,
  output logic [1:0] dibit,
  output logic       sym_valid,
  output logic       sym_err
);
  localparam int Q  = CAR_LEN / 4;
  localparam int PW = $clog2(CAR_LEN);
  localparam int SW = $clog2(SYM_LEN);
  localparam int VW = $clog2(SYM_LEN / CAR_LEN + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [PW-1:0] ph;
  logic [SW-1:0] sc;
  logic y_d, bad, bad_n, rise, on_grid, last, err;
  logic [1:0] k, best_k;
  logic [VW-1:0] vote [4];
  logic [VW-1:0] vote_n [4];
  logic [VW-1:0] best;
  logic [2:0] n_best;
  // Edges at the symbol boundary straddle two symbols, so they never vote
  assign rise    = y & ~y_d & (sc != '0);
  assign on_grid = (ph % PW'(Q)) == '0;
  assign k       = 2'(ph / PW'(Q));
  assign last    = sc == SW'(SYM_LEN - 1);
  always_comb begin
    vote_n = vote;
    if (rise && on_grid) vote_n[k] = vote[k] + 1'b1;
    bad_n = bad | (rise & ~on_grid);
    best = '0;
    best_k = '0;
    n_best = '0;
    for (int i = 0; i < 4; i++)
      if (vote_n[i] > best) begin
        best = vote_n[i];
        best_k = 2'(i);
      end
    for (int i = 0; i < 4; i++) n_best = n_best + 3'(vote_n[i] == best);
    err = (best == '0) | (n_best != 3'd1) | bad_n;
    state_n = last ? RUN : state;
    x = (state == RUN) && ((sc < SW'(SYM_LEN / 2)) ? dibit[1] : dibit[0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ph        <= '0;
      sc        <= '0;
      y_d       <= 1'b0;
      vote      <= '{default: '0};
      bad       <= 1'b0;
      dibit     <= '0;
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
      state     <= IDLE;
    end else begin
      ph        <= (ph == PW'(CAR_LEN - 1)) ? '0 : ph + 1'b1;
      sc        <= last ? '0 : sc + 1'b1;
      y_d       <= y;
      sym_valid <= last;
      state     <= state_n;
      if (last) begin
        dibit   <= best_k;
        sym_err <= err;
        vote    <= '{default: '0};
        bad     <= 1'b0;
      end else begin
        vote    <= vote_n;
        bad     <= bad_n;
      end
    end
  end
endmodule

// File: tb/tb_qpsk_demod.sv
// tb_qpsk_demod: directed checks of the QPSK demodulator with hand-computed expected dibits and bit streams
module tb_qpsk_demod;
  logic clk = 1'b0, rst = 1'b1, y = 1'b0;
  logic x, sym_valid, sym_err;
  logic [1:0] dibit;
  int n_cmp = 0, n_bad = 0, t = 0;
  // Per-symbol y patterns indexed by ph: bit p is y when ph == p
  localparam logic [3:0] K0 = 4'b0011, K1 = 4'b0110, K2 = 4'b1100, K3 = 4'b1001;
  logic [3:0] m_s [4];
  logic [1:0] d_s [4];
  logic       e_s [4];

  qpsk_demod dut (.clk(clk), .rst(rst), .y(y), .x(x), .dibit(dibit), .sym_valid(sym_valid), .sym_err(sym_err));

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] m);
    y = m[t % 4];
    @(negedge clk);
    t++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    y = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      y = i[0];
      @(negedge clk);
      n_cmp++;
      if ({x, dibit, sym_valid, sym_err} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got x/dibit/valid/err=%b want 00000", i, {x, dibit, sym_valid, sym_err});
      end
    end
  endtask

  task automatic test_symbols(input string name, input int n);
    logic [1:0] d;
    logic xe;
    release_rst();
    for (int i = 0; i <= 8 * n; i++) begin
      n_cmp++;
      if (sym_valid !== (i > 0 && i % 8 == 0)) begin
        n_bad++;
        $display("FAIL %s valid t=%0d got %b want %b", name, i, sym_valid, (i > 0 && i % 8 == 0));
      end
      if (i > 0 && i % 8 == 0) begin
        n_cmp++;
        if (dibit !== d_s[i/8-1] || sym_err !== e_s[i/8-1]) begin
          n_bad++;
          $display("FAIL %s decision t=%0d got dibit=%b err=%b want dibit=%b err=%b",
                   name, i, dibit, sym_err, d_s[i/8-1], e_s[i/8-1]);
        end
      end
      d = (i < 8) ? 2'b00 : d_s[i/8-1];
      xe = (i >= 8) && ((i % 8 < 4) ? d[1] : d[0]);
      n_cmp++;
      if (x !== xe) begin
        n_bad++;
        $display("FAIL %s x t=%0d got %b want %b", name, i, x, xe);
      end
      if (i < 8 * n) step(m_s[i/8]);
    end
  endtask

  task automatic test_reset_mid();
    release_rst();
    for (int i = 0; i < 5; i++) step(K3);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({x, dibit, sym_valid, sym_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_reset outputs got %b want 00000", {x, dibit, sym_valid, sym_err});
    end
    rst = 1'b0;
    t = 0;
    for (int i = 0; i <= 8; i++) begin
      n_cmp++;
      if (sym_valid !== (i == 8)) begin
        n_bad++;
        $display("FAIL mid_reset valid t=%0d got %b want %b", i, sym_valid, (i == 8));
      end
      if (i < 8) step(K3);
    end
    n_cmp++;
    if (dibit !== 2'b11 || sym_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset decision got dibit=%b err=%b want dibit=11 err=0", dibit, sym_err);
    end
  endtask

  initial begin
    test_reset();
    m_s = '{K2, K2, K2, K2};
    d_s = '{2'b10, 2'b10, 2'b10, 2'b10};
    e_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    test_symbols("phase2", 3);
    m_s = '{K0, K1, K3, K2};
    d_s = '{2'b00, 2'b01, 2'b11, 2'b10};
    test_symbols("back_to_back", 4);
    m_s = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    d_s = '{2'b00, 2'b00, 2'b00, 2'b00};
    e_s = '{1'b1, 1'b1, 1'b1, 1'b1};
    test_symbols("const0", 2);
    m_s = '{4'b1111, 4'b1111, 4'b1111, 4'b1111};
    test_symbols("const1", 2);
    m_s = '{4'b1010, 4'b1010, 4'b1010, 4'b1010};
    d_s = '{2'b01, 2'b01, 2'b01, 2'b01};
    test_symbols("tie", 2);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
